// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared CPU definitions for the program loader. Contains the
//               instruction width, the loader FSM state encoding, the
//               err_code values and a helper that says which states accept
//               an upstream byte.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    localparam int INSTR_W = 19;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LEN_LO = 4'd1,
        S_LEN_HI = 4'd2,
        S_B0     = 4'd3,
        S_B1     = 4'd4,
        S_B2     = 4'd5,
        S_WRITE  = 4'd6,
        S_CHECK  = 4'd7,
        S_DONE   = 4'd8,
        S_ERR    = 4'd9
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_ZERO_LEN = 2'd1;
    localparam logic [1:0] ERR_LEN_OVF  = 2'd2;
    localparam logic [1:0] ERR_BAD_DATA = 2'd3;

    // States in which the loader consumes a byte from the upstream stream.
    function automatic logic accepts_byte(input state_t s);
        return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_B0) ||
               (s == S_B1)     || (s == S_B2)     || (s == S_CHECK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prog_loader_word_asm.sv
`default_nettype none
// ============================================================================
// Module      : loader_word_asm
// Description : Collects the three bytes of one instruction word (LSB first),
//               flags a third byte with any of bits [7:3] set, and presents
//               the assembled 19-bit word.
// Ports       : clk_i/reset_i  - clock, asynchronous active-high reset
//               cap_b0_i..b2_i - capture strobes for byte 0/1/2
//               byte_i         - incoming byte
//               b2_bad_o       - incoming byte has nonzero bits [7:3]
//               word_o         - {b2[2:0], b1, b0}
// Revision    : 1.0 - initial release
// ============================================================================
module loader_word_asm
    import prog_loader_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               cap_b0_i,
    input  logic               cap_b1_i,
    input  logic               cap_b2_i,
    input  logic [7:0]         byte_i,
    output logic               b2_bad_o,
    output logic [INSTR_W-1:0] word_o
);

    logic [7:0] b0_q;
    logic [7:0] b1_q;
    logic [2:0] b2_q;

    assign b2_bad_o = |byte_i[7:3];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            b0_q <= 8'd0;
            b1_q <= 8'd0;
            b2_q <= 3'd0;
        end else begin
            if (cap_b0_i) b0_q <= byte_i;
            if (cap_b1_i) b1_q <= byte_i;
            // A malformed top byte never reaches the word register.
            if (cap_b2_i && !b2_bad_o) b2_q <= byte_i[2:0];
        end
    end

    assign word_o = {b2_q, b1_q, b0_q};

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Receives a length-prefixed, XOR-checksummed byte frame and
//               writes its 19-bit instruction words into instruction memory
//               while holding the CPU in reset.
// Ports       : clk_i, reset_i (async, active-high)
//               load_start_i              - start pulse (IDLE/DONE/ERR only)
//               byte_valid_i/byte_data_i/byte_ready_o - upstream byte stream
//               imem_we_o/imem_addr_o/imem_wdata_o    - memory write port
//               cpu_hold_o                - CPU held in reset while loading
//               load_done_o/load_err_o/err_code_o     - load status
// Parameter   : ADDR_W (1..16) - instruction-memory address width
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 8
)
(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_start_i,
    input  logic               byte_valid_i,
    input  logic [7:0]         byte_data_i,
    output logic               byte_ready_o,
    output logic               imem_we_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    output logic [INSTR_W-1:0] imem_wdata_o,
    output logic               cpu_hold_o,
    output logic               load_done_o,
    output logic               load_err_o,
    output logic [1:0]         err_code_o
);

    // Memory capacity in words; the 16-bit frame length limits ADDR_W to 16.
    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

    state_t              state_q, state_d;
    logic [1:0]          err_code_q, err_code_d;
    logic                byte_ready_q;
    logic                imem_we_q;
    logic                cpu_hold_q;
    logic                load_done_q;
    logic                load_err_q;
    logic [7:0]          len_lo_q;
    logic [15:0]         len_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic [7:0]          chk_q;

    logic                byte_hs;
    logic                start;
    logic                word_last;
    logic                b2_bad;
    logic [15:0]         len_full;
    logic [INSTR_W-1:0]  word;

    assign byte_hs  = byte_valid_i && byte_ready_q;
    assign start    = load_start_i &&
                      ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
    assign len_full = {byte_data_i, len_lo_q};
    // The counter holds on the final word, so it never wraps past the top address.
    assign word_last = (17'(cnt_q) + 17'd1) == 17'(len_q);

    loader_word_asm u_word_asm (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .cap_b0_i (byte_hs && (state_q == S_B0)),
        .cap_b1_i (byte_hs && (state_q == S_B1)),
        .cap_b2_i (byte_hs && (state_q == S_B2)),
        .byte_i   (byte_data_i),
        .b2_bad_o (b2_bad),
        .word_o   (word)
    );

    always_comb begin
        state_d    = state_q;
        err_code_d = ERR_NONE;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (load_start_i) state_d = S_LEN_LO;
            S_LEN_LO: if (byte_hs) state_d = S_LEN_HI;
            S_LEN_HI: begin
                if (byte_hs) begin
                    if (len_full == 16'd0) begin
                        state_d    = S_ERR;
                        err_code_d = ERR_ZERO_LEN;
                    end else if (17'(len_full) > CAPACITY) begin
                        state_d    = S_ERR;
                        err_code_d = ERR_LEN_OVF;
                    end else begin
                        state_d = S_B0;
                    end
                end
            end
            S_B0: if (byte_hs) state_d = S_B1;
            S_B1: if (byte_hs) state_d = S_B2;
            S_B2: begin
                if (byte_hs) begin
                    if (b2_bad) begin
                        state_d    = S_ERR;
                        err_code_d = ERR_BAD_DATA;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: state_d = word_last ? S_CHECK : S_B0;
            S_CHECK: begin
                if (byte_hs) begin
                    if (byte_data_i == chk_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_ERR;
                        err_code_d = ERR_BAD_DATA;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            cpu_hold_q   <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
            err_code_q   <= ERR_NONE;
            len_lo_q     <= 8'd0;
            len_q        <= 16'd0;
            cnt_q        <= '0;
            chk_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            // Outputs are registered from the next state so they line up with it.
            byte_ready_q <= accepts_byte(state_d);
            imem_we_q    <= (state_d == S_WRITE);

            if (start) begin
                load_done_q <= 1'b0;
                load_err_q  <= 1'b0;
                err_code_q  <= ERR_NONE;
                chk_q       <= 8'd0;
                cnt_q       <= '0;
                cpu_hold_q  <= 1'b1;
            end

            if (byte_hs && (state_q == S_LEN_LO)) len_lo_q <= byte_data_i;
            if (byte_hs && (state_q == S_LEN_HI)) len_q    <= len_full;

            if (byte_hs && ((state_q == S_B0) || (state_q == S_B1) || (state_q == S_B2)))
                chk_q <= chk_q ^ byte_data_i;

            if ((state_q == S_WRITE) && !word_last) cnt_q <= cnt_q + 1'b1;

            if ((state_d == S_DONE) && (state_q != S_DONE)) begin
                load_done_q <= 1'b1;
                cpu_hold_q  <= 1'b0;
            end

            // cpu_hold stays asserted in ERR so a partial program never runs.
            if ((state_d == S_ERR) && (state_q != S_ERR)) begin
                load_err_q <= 1'b1;
                err_code_q <= err_code_d;
            end
        end
    end

    assign byte_ready_o = byte_ready_q;
    assign imem_we_o    = imem_we_q;
    assign imem_addr_o  = cnt_q;
    assign imem_wdata_o = word;
    assign cpu_hold_o   = cpu_hold_q;
    assign load_done_o  = load_done_q;
    assign load_err_o   = load_err_q;
    assign err_code_o   = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader. Frames are built with
//               random or fixed words, a frame-level parser predicts the
//               memory writes and final status, and the observed write
//               stream and status are compared against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_start = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'd0;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [18:0]   imem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic          load_err;
    logic [1:0]    err_code;

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(AW)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .load_start_i (load_start),
        .byte_valid_i (byte_valid),
        .byte_data_i  (byte_data),
        .byte_ready_o (byte_ready),
        .imem_we_o    (imem_we),
        .imem_addr_o  (imem_addr),
        .imem_wdata_o (imem_wdata),
        .cpu_hold_o   (cpu_hold),
        .load_done_o  (load_done),
        .load_err_o   (load_err),
        .err_code_o   (err_code)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]    frame_q[$];
    logic [18:0]   fixed_w[$];
    logic [AW-1:0] got_addr[$];
    logic [18:0]   got_data[$];
    int            exp_addr[$];
    logic [18:0]   exp_data[$];
    bit            exp_done;
    logic [1:0]    exp_code;
    int            consumed;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            got_addr.push_back(imem_addr);
            got_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame: LEN_LO, LEN_HI, n words of 3 bytes LSB first, XOR checksum.
    task automatic build(input int n, input int bad_word, input bit bad_chk);
        logic [18:0] w;
        logic [7:0]  x;
        logic [7:0]  b2;
        frame_q.delete();
        x = 8'd0;
        frame_q.push_back(n[7:0]);
        frame_q.push_back(n[15:8]);
        for (int i = 0; i < n; i++) begin
            w  = (i < fixed_w.size()) ? fixed_w[i] : 19'($urandom);
            b2 = (i == bad_word) ? 8'h08 : {5'd0, w[18:16]};
            frame_q.push_back(w[7:0]);
            frame_q.push_back(w[15:8]);
            frame_q.push_back(b2);
            x = x ^ w[7:0] ^ w[15:8] ^ b2;
        end
        frame_q.push_back(bad_chk ? ~x : x);
    endtask

    // Parses the frame as a receiver would and predicts writes, status and
    // the number of bytes the loader consumes before it stops.
    task automatic model();
        int         n;
        int         pos;
        logic [7:0] x;
        logic [7:0] b0, b1, b2;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 1'b0;
        exp_code = 2'd0;
        x = 8'd0;
        n = int'(frame_q[1]) * 256 + int'(frame_q[0]);
        if (n == 0) begin
            exp_code = 2'd1; consumed = 2; return;
        end
        if (n > (1 << AW)) begin
            exp_code = 2'd2; consumed = 2; return;
        end
        pos = 2;
        for (int i = 0; i < n; i++) begin
            b0 = frame_q[pos]; b1 = frame_q[pos+1]; b2 = frame_q[pos+2];
            pos += 3;
            if (b2 > 8'd7) begin
                exp_code = 2'd3; consumed = pos; return;
            end
            x = x ^ b0 ^ b1 ^ b2;
            exp_addr.push_back(i);
            exp_data.push_back(19'(int'(b2) * 65536 + int'(b1) * 256 + int'(b0)));
        end
        consumed = pos + 1;
        if (frame_q[pos] == x) exp_done = 1'b1;
        else                   exp_code = 2'd3;
    endtask

    // Offers frame bytes with random gaps; garbage is driven on idle cycles.
    task automatic send(input int count, input int gap, input int start_at);
        int idx = 0;
        int cyc = 0;
        bit v;
        bit pulsed = 1'b0;
        while (idx < count && cyc < count * 40 + 100) begin
            @(negedge clk);
            v          = ($urandom_range(99, 0) >= gap);
            byte_valid = v;
            byte_data  = v ? frame_q[idx] : 8'($urandom);
            load_start = (idx == start_at) && !pulsed;
            if (load_start) pulsed = 1'b1;
            if (v && byte_ready) idx++;
            cyc++;
        end
        @(negedge clk);
        byte_valid = 1'b0;
        load_start = 1'b0;
        check("bytes_accepted", idx, count);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int gap, input int start_at);
        model();
        pulse_start();
        got_addr.delete();
        got_data.delete();
        check({tag, "_start_hold"},  cpu_hold,   1);
        check({tag, "_start_done"},  load_done,  0);
        check({tag, "_start_err"},   load_err,   0);
        check({tag, "_start_ready"}, byte_ready, 1);
        send(consumed, gap, start_at);
        repeat (3) @(negedge clk);
        check({tag, "_nwrites"}, got_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            check({tag, "_addr"}, got_addr[i], exp_addr[i]);
            check({tag, "_data"}, got_data[i], exp_data[i]);
        end
        check({tag, "_done"},  load_done,  exp_done);
        check({tag, "_err"},   load_err,   !exp_done);
        check({tag, "_code"},  err_code,   exp_code);
        check({tag, "_hold"},  cpu_hold,   !exp_done);
        check({tag, "_ready"}, byte_ready, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, byte_ready, 0);
        check({tag, "_we"},    imem_we,    0);
        check({tag, "_addr"},  imem_addr,  0);
        check({tag, "_wdata"}, imem_wdata, 0);
        check({tag, "_hold"},  cpu_hold,   0);
        check({tag, "_done"},  load_done,  0);
        check({tag, "_err"},   load_err,   0);
        check({tag, "_code"},  err_code,   0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Two boundary words, no gaps.
        fixed_w.delete();
        fixed_w.push_back(19'h7FFFF);
        fixed_w.push_back(19'h00001);
        build(2, -1, 1'b0);
        run_frame("n2", 0, -1);
        fixed_w.delete();

        // Zero length and length overflow.
        build(0, -1, 1'b0);
        run_frame("n0", 0, -1);
        build(257, -1, 1'b0);
        run_frame("n257", 0, -1);

        // Full memory.
        build(256, -1, 1'b0);
        run_frame("n256", 0, -1);

        // Malformed top byte on word 0, then a bad checksum.
        build(2, 0, 1'b0);
        run_frame("badb2", 0, -1);
        build(1, -1, 1'b1);
        run_frame("badchk", 0, -1);

        // Same frame with and without gaps must write identically.
        build(6, -1, 1'b0);
        run_frame("gap0", 0, -1);
        run_frame("gap50", 50, -1);

        // Random lengths with gaps.
        for (int k = 0; k < 4; k++) begin
            build($urandom_range(20, 1), -1, 1'b0);
            run_frame("rand", 50, -1);
        end

        // load_start mid-frame is ignored.
        build(3, -1, 1'b0);
        run_frame("midstart", 50, 5);

        // Asynchronous reset while waiting for byte 1 of word 0.
        build(4, -1, 1'b0);
        pulse_start();
        got_addr.delete();
        got_data.delete();
        send(3, 0, -1);
        check("pre_rst_hold",  cpu_hold,   1);
        check("pre_rst_ready", byte_ready, 1);
        #2 reset = 1'b1;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_no_write", got_addr.size(), 0);
        build(4, -1, 1'b0);
        run_frame("after_rst", 50, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
